cgr_kmer_gen: RTL and testbench

Parametrised chaos-game-representation (CGR) address generator for nucleotide streams. It sits between the symbol decoder and the CGR count memory. Each accepted 2-bit symbol shifts into a K-deep x/y coordinate window, and the block emits one 2K-bit memory address per symbol once the window is full. Additions over the earlier fixed 8-bit generator:
- valid/ready flow control on input and output
- sequence-boundary and ambiguous-base handling
- optional partial-window emission
- saturating statistics counters

---
 rtl/cgr_kmer_gen.sv | 181 ++++++++++++++++++
 tb/tb_cgr_kmer_gen.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/cgr_kmer_gen.sv
// cgr_kmer_gen: chaos-game-representation address generator.
//   Each accepted 2-bit symbol shifts into a K-deep x/y coordinate window;
//   one {x, y} address of 2K bits is produced per symbol, either only when
//   the window is full or also while it fills (emit_partial).
// Ports:
//   CLK, RST_N            clock, asynchronous active-low reset
//   BC_mode               enable; symbols are accepted only while high
//   emit_partial          emit addresses before the window is full
//   in_valid/in_ready     symbol handshake (symbol, symbol_n, seq_start)
//   out_valid/out_ready   address handshake (addr)
//   wen_cgr               memory write strobe (out_valid & out_ready)
//   fill                  symbols in window, saturates at K
//   sym_count, n_count    saturating counts of accepted / accepted-N symbols
module cgr_kmer_gen #(
  parameter int K     = 8,
  parameter int CNT_W = 16,
  localparam int FW   = $clog2(K + 1)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             BC_mode,
  input  logic             emit_partial,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       symbol,
  input  logic             symbol_n,
  input  logic             seq_start,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*K-1:0]   addr,
  output logic             wen_cgr,
  output logic [FW-1:0]    fill,
  output logic [CNT_W-1:0] sym_count,
  output logic [CNT_W-1:0] n_count
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_STREAM = 2'd2
  } state_t;

  localparam logic [FW-1:0] K_F = FW'(K);

  state_t           state_q, state_d;
  logic [K-1:0]     x_q, x_d, y_q, y_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic [2*K-1:0]   addr_q, addr_d;
  logic             out_valid_q, out_valid_d;
  logic [CNT_W-1:0] sym_q, sym_d, n_q, n_d;

  logic             acc_s, emit_s;
  logic [K-1:0]     base_x_s, base_y_s, shift_x_s, shift_y_s;
  logic [FW-1:0]    fill_base_s, fill_inc_s;

  // Saturating increment: holds at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      sat_inc = v;
    end else begin
      sat_inc = v + CNT_W'(1'b1);
    end
  endfunction

  // State and datapath registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= ST_IDLE;
      x_q         <= {K{1'b0}};
      y_q         <= {K{1'b0}};
      fill_q      <= {FW{1'b0}};
      addr_q      <= {(2*K){1'b0}};
      out_valid_q <= 1'b0;
      sym_q       <= {CNT_W{1'b0}};
      n_q         <= {CNT_W{1'b0}};
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      fill_q      <= fill_d;
      addr_q      <= addr_d;
      out_valid_q <= out_valid_d;
      sym_q       <= sym_d;
      n_q         <= n_d;
    end
  end

  // Window shift, fill, counters and output-register next state.
  always_comb begin
    acc_s = in_valid & in_ready;
    // seq_start clears the window before the new symbol is shifted in.
    if (seq_start) begin
      base_x_s    = {K{1'b0}};
      base_y_s    = {K{1'b0}};
      fill_base_s = {FW{1'b0}};
    end else begin
      base_x_s    = x_q;
      base_y_s    = y_q;
      fill_base_s = fill_q;
    end
    // Newest symbol enters at the MSB; the oldest falls off bit 0.
    shift_x_s        = base_x_s >> 1;
    shift_x_s[K-1]   = symbol[1];
    shift_y_s        = base_y_s >> 1;
    shift_y_s[K-1]   = symbol[0];
    if (fill_base_s == K_F) begin
      fill_inc_s = K_F;
    end else begin
      fill_inc_s = fill_base_s + FW'(1'b1);
    end

    x_d    = x_q;
    y_d    = y_q;
    fill_d = fill_q;
    sym_d  = sym_q;
    n_d    = n_q;
    emit_s = 1'b0;
    if (acc_s) begin
      sym_d = sat_inc(sym_q);
      if (symbol_n) begin
        // An ambiguous base breaks the k-mer: restart the window, emit nothing.
        x_d    = {K{1'b0}};
        y_d    = {K{1'b0}};
        fill_d = {FW{1'b0}};
        n_d    = sat_inc(n_q);
        emit_s = 1'b0;
      end else begin
        x_d    = shift_x_s;
        y_d    = shift_y_s;
        fill_d = fill_inc_s;
        emit_s = (fill_inc_s == K_F) | emit_partial;
      end
    end else begin
      emit_s = 1'b0;
    end

    addr_d = addr_q;
    if (emit_s) begin
      out_valid_d = 1'b1;
      addr_d      = {shift_x_s, shift_y_s};
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // FSM next state; BC_mode low forces IDLE from any state.
  always_comb begin
    state_d = state_q;
    if (!BC_mode) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:   state_d = (fill_q == K_F) ? ST_STREAM : ST_FILL;
        ST_FILL:   state_d = (fill_d == K_F) ? ST_STREAM : ST_FILL;
        ST_STREAM: begin
          if (acc_s && (symbol_n || seq_start)) begin
            state_d = (fill_d == K_F) ? ST_STREAM : ST_FILL;
          end else begin
            state_d = ST_STREAM;
          end
        end
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  // Handshake outputs. RST_N gating keeps in_ready low while reset is held.
  always_comb begin
    in_ready = RST_N & BC_mode & (~out_valid_q | out_ready);
    wen_cgr  = out_valid_q & out_ready;
  end

  assign out_valid = out_valid_q;
  assign addr      = addr_q;
  assign fill      = fill_q;
  assign sym_count = sym_q;
  assign n_count   = n_q;

endmodule

// File: tb/tb_cgr_kmer_gen.sv
// Self-checking bench for cgr_kmer_gen: directed scenarios followed by
// randomized traffic, all compared each cycle against a window model that
// keeps the accepted symbols in a queue and computes addresses arithmetically.
module tb_cgr_kmer_gen;

  localparam int K     = 8;
  localparam int CNT_W = 6;
  localparam int FW    = $clog2(K + 1);
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             CLK = 1'b0;
  logic             RST_N = 1'b0;
  logic             BC_mode = 1'b0, emit_partial = 1'b0, in_valid = 1'b0;
  logic             in_ready;
  logic [1:0]       symbol = 2'b00;
  logic             symbol_n = 1'b0, seq_start = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [2*K-1:0]   addr;
  logic             wen_cgr;
  logic [FW-1:0]    fill;
  logic [CNT_W-1:0] sym_count, n_count;

  int checks = 0;
  int failures = 0;

  // Model: newest symbol at index 0.
  int m_win[$];
  bit m_ov;
  int m_addr, m_sym, m_n;

  cgr_kmer_gen #(.K(K), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST_N(RST_N), .BC_mode(BC_mode), .emit_partial(emit_partial),
    .in_valid(in_valid), .in_ready(in_ready), .symbol(symbol),
    .symbol_n(symbol_n), .seq_start(seq_start), .out_valid(out_valid),
    .out_ready(out_ready), .addr(addr), .wen_cgr(wen_cgr), .fill(fill),
    .sym_count(sym_count), .n_count(n_count)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Symbol at age a sits at bit K-1-a of its axis.
  function automatic int win_addr();
    int x = 0, y = 0;
    for (int a = 0; a < m_win.size(); a++) begin
      if ((m_win[a] & 2) != 0) x += 1 << (K - 1 - a);
      if ((m_win[a] & 1) != 0) y += 1 << (K - 1 - a);
    end
    return (x << K) + y;
  endfunction

  function automatic int sat(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  task automatic drv(input bit bc, input bit ep, input bit v, input int s,
                     input bit n, input bit ss, input bit ordy);
    BC_mode = bc; emit_partial = ep; in_valid = v; symbol = s[1:0];
    symbol_n = n; seq_start = ss; out_ready = ordy;
  endtask

  // One clock cycle: inputs already driven just after a falling edge.
  task automatic tick();
    bit rdy, emit;
    #1;
    rdy = BC_mode && (!m_ov || out_ready);
    check_eq("in_ready", in_ready, rdy);
    check_eq("wen_cgr", wen_cgr, m_ov && out_ready);
    emit = 1'b0;
    if (in_valid && rdy) begin
      m_sym = sat(m_sym);
      if (symbol_n) begin
        m_win.delete();
        m_n = sat(m_n);
      end else begin
        if (seq_start) m_win.delete();
        m_win.push_front(int'(symbol));
        if (m_win.size() > K) void'(m_win.pop_back());
        emit = (m_win.size() == K) || emit_partial;
      end
    end
    if (emit) begin
      m_ov = 1'b1;
      m_addr = win_addr();
    end else if (out_ready) begin
      m_ov = 1'b0;
    end
    @(posedge CLK);
    #1;
    check_eq("out_valid", out_valid, m_ov);
    if (m_ov) check_eq("addr", addr, m_addr);
    check_eq("fill", fill, m_win.size());
    check_eq("sym_count", sym_count, m_sym);
    check_eq("n_count", n_count, m_n);
    @(negedge CLK);
  endtask

  task automatic model_clear();
    m_win.delete();
    m_ov = 1'b0; m_addr = 0; m_sym = 0; m_n = 0;
  endtask

  // Asynchronous reset applied between edges; outputs must clear at once.
  task automatic do_reset();
    #1 RST_N = 1'b0;
    #1;
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_in_ready", in_ready, 0);
    check_eq("rst_wen", wen_cgr, 0);
    check_eq("rst_addr", addr, 0);
    check_eq("rst_fill", fill, 0);
    check_eq("rst_sym", sym_count, 0);
    check_eq("rst_n", n_count, 0);
    model_clear();
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  initial begin
    model_clear();
    drv(0, 0, 0, 0, 0, 0, 0);
    @(negedge CLK);
    do_reset();

    // Full window of 2'b11 -> 16'hFFFF, then idle to see the write strobe.
    for (int i = 0; i < 8; i++) begin drv(1, 0, 1, 3, 0, 0, 1); tick(); end
    check_eq("full_addr", addr, 16'hFFFF);
    check_eq("full_fill", fill, 8);
    check_eq("full_sym", sym_count, 8);
    drv(1, 0, 0, 0, 0, 0, 1); tick();

    // Shift order: 2'b10 then 7x 2'b00 -> 16'h0100; then 2'b01 -> 16'h0080.
    drv(1, 0, 1, 2, 0, 1, 1); tick();
    for (int i = 0; i < 7; i++) begin drv(1, 0, 1, 0, 0, 0, 1); tick(); end
    check_eq("shift_addr", addr, 16'h0100);
    drv(1, 0, 1, 1, 0, 0, 1); tick();
    check_eq("shift9_addr", addr, 16'h0080);

    // Partial emission and N handling.
    drv(1, 1, 1, 3, 0, 1, 1); tick();
    check_eq("part_addr", addr, 16'h8080);
    drv(1, 1, 1, 0, 1, 0, 1); tick();
    check_eq("n_fill", fill, 0);
    drv(1, 1, 1, 1, 0, 0, 1); tick();
    check_eq("after_n_addr", addr, 16'h0080);

    // Backpressure: stream, stall 5 cycles, release.
    for (int i = 0; i < 10; i++) begin drv(1, 0, 1, $urandom_range(0, 3), 0, 0, 1); tick(); end
    for (int i = 0; i < 5; i++) begin drv(1, 0, 1, $urandom_range(0, 3), 0, 0, 0); tick(); end
    for (int i = 0; i < 6; i++) begin drv(1, 0, 1, $urandom_range(0, 3), 0, 0, 1); tick(); end

    // seq_start in STREAM restarts the window.
    drv(1, 0, 1, 3, 0, 1, 1); tick();
    check_eq("ss_fill", fill, 1);
    for (int i = 0; i < 7; i++) begin drv(1, 0, 1, 2, 0, 0, 1); tick(); end
    check_eq("ss_refilled", out_valid, 1);

    // Enable drop mid-fill at fill=3, then resume.
    drv(1, 0, 1, 1, 0, 1, 1); tick();
    for (int i = 0; i < 2; i++) begin drv(1, 0, 1, 2, 0, 0, 1); tick(); end
    for (int i = 0; i < 3; i++) begin drv(0, 0, 1, 3, 0, 0, 1); tick(); end
    check_eq("bc_hold_fill", fill, 3);
    drv(1, 0, 1, 3, 0, 0, 1); tick();
    check_eq("bc_resume_fill", fill, 4);

    // Reset while an address is pending and stalled.
    for (int i = 0; i < 4; i++) begin drv(1, 1, 1, 1, 0, 0, 0); tick(); end
    drv(1, 1, 1, 1, 0, 0, 0);
    do_reset();

    // Randomized traffic; counters saturate at CNT_W=6 during this phase.
    for (int c = 0; c < 3000; c++) begin
      if (c % 256 == 0) emit_partial = 1'($urandom_range(0, 1));
      drv(($urandom_range(0, 19) != 0), emit_partial, ($urandom_range(0, 4) != 0),
          $urandom_range(0, 3), ($urandom_range(0, 15) == 0),
          ($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0));
      tick();
    end
    check_eq("sym_sat", sym_count, CMAX);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
